// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, PC increment and the
// instruction-memory word-index slice.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL,
        ST_FAULT
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;
    localparam int          IDX_HI = 13;
    localparam int          IDX_LO = 2;

    // Word index the instruction memory decodes from a byte address.
    function automatic logic [IDX_HI-IDX_LO:0] word_index(input logic [31:0] addr);
        return addr[IDX_HI:IDX_LO];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, instruction register and valid/ready output.
// Optional range check on fetch and redirect addresses: FETCH_BOUND_CHECK_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] ir_pc_plus4,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        fault
);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    // First byte address past the populated instruction words.
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << IDX_LO;

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc, r_ir, r_ir_pc;
    logic         r_ir_valid, r_fault;

    logic [31:0]  w_pc_next, w_ir_next, w_ir_pc_next;
    logic         w_valid_next, w_fault_next;
    logic         w_capture;
    logic         w_fetch_oob;
    logic         w_redir_bad;

    assign w_fetch_oob = BOUND_EN && ({1'b0, r_pc} >= MEM_BYTES);
    assign w_redir_bad = (redirect_pc[1:0] != 2'b00)
                      || (BOUND_EN && ({1'b0, redirect_pc} >= MEM_BYTES));

    always_comb begin
        // NOTE: every output of this block gets a default here, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_ir_pc_next = r_ir_pc;
        w_valid_next = r_ir_valid;
        w_fault_next = r_fault;
        w_capture    = 1'b0;

        if (r_state == ST_FAULT) begin
            w_valid_next = 1'b0;
        end else if (redirect) begin
            // A redirect discards any held word, even one being consumed now.
            w_valid_next = 1'b0;
            if (w_redir_bad) begin
                w_fault_next = 1'b1;
                w_state_next = ST_FAULT;
            end else begin
                w_pc_next    = redirect_pc;
                w_state_next = ST_FETCH;
            end
        end else begin
            unique case (r_state)
                ST_IDLE:  w_state_next = ST_FETCH;
                ST_FETCH: w_capture    = 1'b1;
                ST_FULL:  w_capture    = ir_ready;
                default:  w_capture    = 1'b0;
            endcase
        end

        if (w_capture) begin
            if (w_fetch_oob) begin
                w_fault_next = 1'b1;
                w_valid_next = 1'b0;
                w_state_next = ST_FAULT;
            end else begin
                w_ir_next    = imem_instr;
                w_ir_pc_next = r_pc;
                w_pc_next    = r_pc + PC_INC;
                w_valid_next = 1'b1;
                w_state_next = ST_FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ir_pc    <= w_ir_pc_next;
            r_ir_valid <= w_valid_next;
            r_fault    <= w_fault_next;
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_pc_plus4 = r_ir_pc + PC_INC;
    assign ir_valid    = r_ir_valid;
    assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural fetch model. Honours FETCH_BOUND_CHECK_EN like the DUT.
module tb_fetch_unit;

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] ir, ir_pc, ir_pc_plus4, pc;
    logic        ir_valid, fault;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the fetch front end.
    logic [31:0] m_pc = '0, m_ir = '0, m_ir_pc = '0;
    logic        m_valid = 1'b0, m_fault = 1'b0, m_settle = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory: word index in the low bits of each word.
    assign imem_instr = BASE + 32'(imem_addr[13:2]);

    fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_pc_plus4(ir_pc_plus4),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (pc),
        .fault      (fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return BASE + (a % 32'h4000) / 4;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
        return BOUND_EN && (a >= 32'd256);
    endfunction

    // One clock edge: the consumer either takes the word or the slot is empty,
    // and a new word is fetched; redirects, faults and reset take precedence.
    task automatic model_edge();
        if (reset) begin
            m_pc = 32'h0; m_ir = '0; m_ir_pc = '0;
            m_valid = 1'b0; m_fault = 1'b0; m_settle = 1'b1;
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (redirect) begin
            m_valid = 1'b0;
            if (redirect_pc % 4 != 0 || out_of_range(redirect_pc)) m_fault = 1'b1;
            else begin
                m_pc = redirect_pc;
                m_settle = 1'b0;
            end
        end else if (m_settle) begin
            m_settle = 1'b0;
        end else if (!m_valid || ir_ready) begin
            if (out_of_range(m_pc)) begin
                m_fault = 1'b1; m_valid = 1'b0;
            end else begin
                m_ir = mem_word(m_pc); m_ir_pc = m_pc;
                m_pc = m_pc + 4; m_valid = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic restart();
        reset = 1'b1; redirect = 1'b0; ir_ready = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if ({pc, ir, ir_pc, ir_valid, fault} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: pc=%h ir=%h ir_pc=%h valid=%b fault=%b, want all zero",
                     pc, ir, ir_pc, ir_valid, fault);
        end
        reset = 1'b0;
        cycle();
        n_checks++;
        if (pc !== 32'h0 || ir_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_settle: pc=%h valid=%b, want pc=0 valid=0", pc, ir_valid);
        end
        cycle();
        n_checks++;
        if (ir !== BASE || ir_pc !== 32'h0 || ir_valid !== 1'b1 || pc !== 32'h4) begin
            n_errors++;
            $display("FAIL reset_first_word: ir=%h ir_pc=%h valid=%b pc=%h, want %h 0 1 4",
                     ir, ir_pc, ir_valid, pc, BASE);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ir_pc !== 32'(4 * i) || ir !== BASE + 32'(i) || ir_valid !== 1'b1
                || ir_pc_plus4 !== 32'(4 * i + 4)) begin
                n_errors++;
                $display("FAIL stream_%0d: ir=%h ir_pc=%h plus4=%h valid=%b, want %h %h %h 1",
                         i, ir, ir_pc, ir_pc_plus4, ir_valid, BASE + 32'(i), 32'(4 * i), 32'(4 * i + 4));
            end
            ir_ready = 1'b1;
            cycle();
        end
    endtask

    task automatic test_backpressure();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (ir !== BASE + 32'd5 || ir_pc !== 32'd20 || pc !== 32'd24
                || imem_addr !== 32'd24 || ir_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL hold_%0d: ir=%h ir_pc=%h pc=%h addr=%h valid=%b, want %h 14 18 18 1",
                         i, ir, ir_pc, pc, imem_addr, ir_valid, BASE + 32'd5);
            end
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h14; ir_ready = 1'b1;
        cycle();
        n_checks++;
        if (ir_valid !== 1'b0 || pc !== 32'h14) begin
            n_errors++;
            $display("FAIL redirect_bubble: valid=%b pc=%h, want 0 14", ir_valid, pc);
        end
        redirect = 1'b0; ir_ready = 1'b0;
        cycle();
        n_checks++;
        if (ir !== BASE + 32'd5 || ir_pc !== 32'h14 || ir_valid !== 1'b1
            || pc !== 32'h18 || ir_pc_plus4 !== 32'h18) begin
            n_errors++;
            $display("FAIL redirect_target: ir=%h ir_pc=%h valid=%b pc=%h plus4=%h, want %h 14 1 18 18",
                     ir, ir_pc, ir_valid, pc, ir_pc_plus4, BASE + 32'd5);
        end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h16;
        cycle();
        n_checks++;
        if (fault !== 1'b1 || ir_valid !== 1'b0 || pc !== 32'h18) begin
            n_errors++;
            $display("FAIL misaligned: fault=%b valid=%b pc=%h, want 1 0 18", fault, ir_valid, pc);
        end
        redirect_pc = 32'h0; ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (fault !== 1'b1 || ir_valid !== 1'b0 || pc !== 32'h18) begin
                n_errors++;
                $display("FAIL fault_sticky_%0d: fault=%b valid=%b pc=%h, want 1 0 18",
                         i, fault, ir_valid, pc);
            end
        end
        redirect = 1'b0; ir_ready = 1'b0; reset = 1'b1;
        cycle();
        n_checks++;
        if (fault !== 1'b0 || pc !== 32'h0 || ir_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_reset: fault=%b pc=%h valid=%b, want 0 0 0", fault, pc, ir_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_bound();
        logic [31:0] want_ir;
        restart();
        redirect = 1'b1; redirect_pc = 32'hF8; ir_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            want_ir = BASE + 32'd62 + 32'(i);
            n_checks++;
            if (ir !== want_ir || ir_pc !== 32'hF8 + 32'(4 * i) || ir_valid !== 1'b1 || fault !== 1'b0) begin
                n_errors++;
                $display("FAIL bound_word_%0d: ir=%h ir_pc=%h valid=%b fault=%b, want %h %h 1 0",
                         i, ir, ir_pc, ir_valid, fault, want_ir, 32'hF8 + 32'(4 * i));
            end
        end
        cycle();
        n_checks++;
        if (BOUND_EN) begin
            if (fault !== 1'b1 || ir_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL bound_fault: fault=%b valid=%b, want 1 0", fault, ir_valid);
            end
        end else if (ir !== BASE + 32'd64 || ir_pc !== 32'h100 || ir_valid !== 1'b1 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL bound_unchecked: ir=%h ir_pc=%h valid=%b fault=%b, want %h 100 1 0",
                     ir, ir_pc, ir_valid, fault, BASE + 32'd64);
        end
`ifdef FETCH_BOUND_CHECK_EN
        restart();
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || ir_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bound_redirect: fault=%b valid=%b, want 1 0", fault, ir_valid);
        end
`endif
    endtask

`ifndef FETCH_BOUND_CHECK_EN
    task automatic test_wrap();
        restart();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; ir_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        cycle();
        n_checks++;
        if (ir !== BASE + 32'hFFF || ir_pc !== 32'hFFFF_FFFC || pc !== 32'h0
            || ir_pc_plus4 !== 32'h0 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_last: ir=%h ir_pc=%h pc=%h plus4=%h fault=%b, want %h fffffffc 0 0 0",
                     ir, ir_pc, pc, ir_pc_plus4, fault, BASE + 32'hFFF);
        end
        cycle();
        n_checks++;
        if (ir !== BASE || ir_pc !== 32'h0 || ir_valid !== 1'b1 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_first: ir=%h ir_pc=%h valid=%b fault=%b, want %h 0 1 0",
                     ir, ir_pc, ir_valid, fault, BASE);
        end
    endtask
`endif

    task automatic test_random();
        int r;
        restart();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            reset       = (r < 2);
            redirect    = (r >= 2 && r < 14);
            redirect_pc = 32'($urandom_range(0, 127)) << 2;
            if (r >= 2 && r < 5) redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
            ir_ready    = ($urandom_range(0, 3) != 0);
            cycle();
            n_checks++;
            if ({ir, ir_pc, ir_pc_plus4, ir_valid, pc, imem_addr, fault}
                !== {m_ir, m_ir_pc, m_ir_pc + 32'd4, m_valid, m_pc, m_pc, m_fault}) begin
                n_errors++;
                $display("FAIL random_%0d: ir=%h ir_pc=%h valid=%b pc=%h addr=%h fault=%b, want %h %h %b %h %h %b",
                         i, ir, ir_pc, ir_valid, pc, imem_addr, fault,
                         m_ir, m_ir_pc, m_valid, m_pc, m_pc, m_fault);
            end
        end
        reset = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_bound();
`ifndef FETCH_BOUND_CHECK_EN
        test_wrap();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
